// File: rtl/operand_sign_capture_if.sv
// Operand handshake between the switch capture block and the arithmetic core.
// The capture block drives the master side; the core drives op_ready.
interface operand_sign_capture_if;
  logic        op_valid;
  logic        op_ready;
  logic        sign_value;
  logic [31:0] value;

  modport master (
    output op_valid,
    output sign_value,
    output value,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  sign_value,
    input  value,
    output op_ready
  );
endinterface

// File: rtl/operand_sign_capture.sv
// Operand capture: debounces the active-low load button, samples the switches
// once per accepted press and offers sign + magnitude over valid/ready.
// Optional feature macro: SIGNED_INPUT_EN (switches are two's complement when
// defined; plain unsigned with sign_value tied low otherwise).
module operand_sign_capture #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  load_btn_n,
  operand_sign_capture_if.master op,
  output logic                  busy
);

  localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StCapture,
    StOffer,
    StWaitRelease
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [1:0]            sync_q;
  logic                  pressed_s;
  logic                  op_valid_q;
  logic                  sign_q;
  logic [31:0]           value_q;

  logic                  sw_sign;
  logic [DATA_WIDTH:0]   sw_mag;

  // Two-flop synchronizer for the asynchronous button; flops rest at 1 (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], load_btn_n};
    end
  end

  assign pressed_s = ~sync_q[1];

`ifdef SIGNED_INPUT_EN
  logic [DATA_WIDTH:0] sw_ext;

  // Sign-extend by one bit so the most-negative input negates without overflow.
  always_comb begin
    sw_ext  = {sw_data[DATA_WIDTH-1], sw_data};
    sw_sign = sw_data[DATA_WIDTH-1];
    sw_mag  = sw_sign ? (~sw_ext + (DATA_WIDTH + 1)'(1)) : sw_ext;
  end
`else
  // Unsigned switches: magnitude is the raw value, sign never set.
  always_comb begin
    sw_sign = 1'b0;
    sw_mag  = {1'b0, sw_data};
  end
`endif

  // Control FSM with registered handshake and operand outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      value_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pressed_s) begin
            cnt_q   <= '0;
            state_q <= StDebounce;
          end
        end
        StDebounce: begin
          if (!pressed_s) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StCapture: begin
          sign_q     <= sw_sign;
          value_q    <= 32'(sw_mag);
          op_valid_q <= 1'b1;
          state_q    <= StOffer;
        end
        StOffer: begin
          // Operand is frozen here; switches and button are ignored.
          if (op.op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= StWaitRelease;
          end
        end
        StWaitRelease: begin
          // One press yields one operand: require a release before re-arming.
          if (!pressed_s) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign op.op_valid   = op_valid_q;
  assign op.sign_value = sign_q;
  assign op.value      = value_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_operand_sign_capture.sv
// Directed bench for operand_sign_capture with DEBOUNCE_CYCLES = 4.
// Expected operands follow SIGNED_INPUT_EN as seen by this compile.
module tb_operand_sign_capture;

  logic        clk;
  logic        reset;
  logic [15:0] sw_data;
  logic        load_btn_n;
  logic        busy;
  int          n_cmp;
  int          n_fail;

  operand_sign_capture_if op_if ();

  operand_sign_capture #(
    .DATA_WIDTH     (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_data   (sw_data),
    .load_btn_n(load_btn_n),
    .op        (op_if),
    .busy      (busy)
  );

`ifdef SIGNED_INPUT_EN
  localparam logic        SignFffb  = 1'b1;
  localparam logic [31:0] ValFffb   = 32'd5;
  localparam logic        Sign8000  = 1'b1;
  localparam logic [31:0] Val8000   = 32'h0000_8000;
  localparam logic        SignFf00  = 1'b1;
  localparam logic [31:0] ValFf00   = 32'd256;
`else
  localparam logic        SignFffb  = 1'b0;
  localparam logic [31:0] ValFffb   = 32'h0000_FFFB;
  localparam logic        Sign8000  = 1'b0;
  localparam logic [31:0] Val8000   = 32'h0000_8000;
  localparam logic        SignFf00  = 1'b0;
  localparam logic [31:0] ValFf00   = 32'h0000_FF00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the button until op_valid appears (bounded).
  task automatic press_until_valid(output bit seen);
    seen       = 1'b0;
    load_btn_n = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (op_if.op_valid) seen = 1'b1;
    end
  endtask

  // Release the button and wait for the FSM to return to idle (bounded).
  task automatic release_and_idle(output bit idle_ok);
    load_btn_n = 1'b1;
    idle_ok    = 1'b0;
    for (int i = 0; i < 20 && !idle_ok; i++) begin
      step();
      if (!busy) idle_ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    load_btn_n     = 1'b1;
    sw_data        = 16'h0000;
    op_if.op_ready = 1'b0;
    step();
    step();
    n_cmp += 4;
    if (op_if.op_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", op_if.op_valid);
    end
    if (op_if.sign_value !== 1'b0) begin
      n_fail++; $display("FAIL reset_sign: got %b expected 0", op_if.sign_value);
    end
    if (op_if.value !== 32'd0) begin
      n_fail++; $display("FAIL reset_value: got %h expected 0", op_if.value);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    step();
  endtask

  // 8-cycle press of 0xFFFB with op_ready high; op_valid rises 7 edges after press.
  task automatic test_basic();
    bit idle_ok;
    sw_data        = 16'hFFFB;
    op_if.op_ready = 1'b1;
    load_btn_n     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++;
      if (op_if.op_valid !== (i == 7)) begin
        n_fail++;
        $display("FAIL basic_valid_timing edge %0d: got %b expected %b", i, op_if.op_valid,
                 (i == 7));
      end
      if (i == 7) begin
        n_cmp += 2;
        if (op_if.sign_value !== SignFffb) begin
          n_fail++; $display("FAIL basic_sign: got %b expected %b", op_if.sign_value, SignFffb);
        end
        if (op_if.value !== ValFffb) begin
          n_fail++; $display("FAIL basic_value: got %h expected %h", op_if.value, ValFffb);
        end
        load_btn_n = 1'b1;
      end
    end
    release_and_idle(idle_ok);
    n_cmp++;
    if (!idle_ok) begin
      n_fail++; $display("FAIL basic_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_most_negative();
    bit seen;
    bit idle_ok;
    sw_data        = 16'h8000;
    op_if.op_ready = 1'b1;
    press_until_valid(seen);
    n_cmp += 3;
    if (!seen) begin
      n_fail++; $display("FAIL mostneg_valid: got 0 expected 1");
    end
    if (op_if.sign_value !== Sign8000) begin
      n_fail++; $display("FAIL mostneg_sign: got %b expected %b", op_if.sign_value, Sign8000);
    end
    if (op_if.value !== Val8000) begin
      n_fail++; $display("FAIL mostneg_value: got %h expected %h", op_if.value, Val8000);
    end
    release_and_idle(idle_ok);
  endtask

  task automatic test_zero();
    bit seen;
    bit idle_ok;
    sw_data        = 16'h0000;
    op_if.op_ready = 1'b1;
    press_until_valid(seen);
    n_cmp += 3;
    if (!seen) begin
      n_fail++; $display("FAIL zero_valid: got 0 expected 1");
    end
    if (op_if.sign_value !== 1'b0) begin
      n_fail++; $display("FAIL zero_sign: got %b expected 0", op_if.sign_value);
    end
    if (op_if.value !== 32'd0) begin
      n_fail++; $display("FAIL zero_value: got %h expected 0", op_if.value);
    end
    release_and_idle(idle_ok);
  endtask

  // Two-cycle glitch: enters debounce but never produces an operand.
  task automatic test_bounce();
    int valid_seen;
    bit busy_seen;
    valid_seen     = 0;
    busy_seen      = 1'b0;
    sw_data        = 16'h1234;
    op_if.op_ready = 1'b1;
    load_btn_n     = 1'b0;
    step();
    step();
    load_btn_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_seen = 1'b1;
      if (op_if.op_valid) valid_seen++;
      step();
    end
    n_cmp += 3;
    if (valid_seen !== 0) begin
      n_fail++; $display("FAIL bounce_no_valid: got %0d valid cycles expected 0", valid_seen);
    end
    if (busy_seen !== 1'b1) begin
      n_fail++; $display("FAIL bounce_debounce_entered: got %b expected 1", busy_seen);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL bounce_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    bit idle_ok;
    int extra;
    sw_data        = 16'h0003;
    op_if.op_ready = 1'b0;
    press_until_valid(seen);
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL bp_valid: got 0 expected 1");
    end
    sw_data = 16'hFF00;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp += 3;
      if (op_if.op_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_valid cycle %0d: got %b expected 1", i, op_if.op_valid);
      end
      if (op_if.value !== 32'd3) begin
        n_fail++; $display("FAIL bp_hold_value cycle %0d: got %h expected 3", i, op_if.value);
      end
      if (op_if.sign_value !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_sign cycle %0d: got %b expected 0", i, op_if.sign_value);
      end
    end
    op_if.op_ready = 1'b1;
    step();
    n_cmp += 3;
    if (op_if.op_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_transfer: got %b expected 0", op_if.op_valid);
    end
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_wait_release_busy: got %b expected 1", busy);
    end
    if (op_if.value !== 32'd3) begin
      n_fail++; $display("FAIL bp_value_kept: got %h expected 3", op_if.value);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (op_if.op_valid) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL bp_one_per_press: got %0d valid cycles expected 0", extra);
    end
    release_and_idle(idle_ok);
    press_until_valid(seen);
    n_cmp += 3;
    if (!seen) begin
      n_fail++; $display("FAIL bp_repress_valid: got 0 expected 1");
    end
    if (op_if.sign_value !== SignFf00) begin
      n_fail++; $display("FAIL bp_repress_sign: got %b expected %b", op_if.sign_value, SignFf00);
    end
    if (op_if.value !== ValFf00) begin
      n_fail++; $display("FAIL bp_repress_value: got %h expected %h", op_if.value, ValFf00);
    end
    release_and_idle(idle_ok);
  endtask

  task automatic test_reset_in_offer();
    bit seen;
    int late;
    sw_data        = 16'hFFFB;
    op_if.op_ready = 1'b0;
    press_until_valid(seen);
    load_btn_n = 1'b1;
    reset      = 1'b1;
    step();
    n_cmp += 4;
    if (op_if.op_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_offer_valid: got %b expected 0", op_if.op_valid);
    end
    if (op_if.value !== 32'd0) begin
      n_fail++; $display("FAIL rst_offer_value: got %h expected 0", op_if.value);
    end
    if (op_if.sign_value !== 1'b0) begin
      n_fail++; $display("FAIL rst_offer_sign: got %b expected 0", op_if.sign_value);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_offer_busy: got %b expected 0", busy);
    end
    reset          = 1'b0;
    op_if.op_ready = 1'b1;
    late           = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (op_if.op_valid) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_fail++; $display("FAIL rst_offer_discard: got %0d valid cycles expected 0", late);
    end
  endtask

  // Reset while the button is held must re-debounce and capture again.
  task automatic test_reset_held();
    bit seen;
    bit idle_ok;
    sw_data        = 16'h0001;
    op_if.op_ready = 1'b1;
    press_until_valid(seen);
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL held_wait_release: got busy %b expected 1", busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL held_reset_busy: got %b expected 0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (op_if.op_valid) seen = 1'b1;
    end
    n_cmp += 2;
    if (!seen) begin
      n_fail++; $display("FAIL held_recapture_valid: got 0 expected 1");
    end
    if (op_if.value !== 32'd1) begin
      n_fail++; $display("FAIL held_recapture_value: got %h expected 1", op_if.value);
    end
    release_and_idle(idle_ok);
    n_cmp++;
    if (!idle_ok) begin
      n_fail++; $display("FAIL held_idle: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_most_negative();
    test_zero();
    test_bounce();
    test_backpressure();
    test_reset_in_offer();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
